spi_slave16: RTL
================

// Module: spi_slave16
// PURPOSE
// - SPI responder: the receiving end of the 16-bit SPI master link (SCLK, SS_n, MOSI, MISO).
// - Captures one 16-bit frame per SS_n low period. Presents it on rx_data with a one-clock rx_rdy pulse.
// - Shifts out a preloaded 16-bit tx word on MISO in the same frame.
// - Sits on the peripheral side. All SPI pins are asynchronous to clk and are synchronized internally.
// PARAMETERS
// DATA_W       16  frame length in bits (bit counter width = $clog2(DATA_W)+1)
// SYNC_STAGES  2   flop stages on SCLK/SS_n/MOSI before edge detection (>=2)
// PORTS
// clk       in   1       system clock (>= 8x SCLK)
// rst       in   1       synchronous, active-high reset
// SCLK      in   1       SPI clock from master, idles low
// SS_n      in   1       active-low frame select from master
// MOSI      in   1       serial data from master, MSB first
// MISO      out  1       serial data to master, MSB first
// MISO_en   out  1       high while frame active (pad tri-state enable)
// tx_wrt    in   1       load tx_data into pending tx word (one-clock strobe)
// tx_data   in   DATA_W  word to return in next frame
// rx_data   out  DATA_W  last complete frame received
// rx_rdy    out  1       one-clock pulse: rx_data updated
// frm_err   out  1       one-clock pulse: frame ended with bit count != DATA_W
// busy      out  1       frame in progress (state==SHIFT)
// BEHAVIOUR
// - Reset (rst high at posedge clk) gives:
//   - MISO=0, MISO_en=0, rx_data=0, rx_rdy=0, frm_err=0, busy=0
//   - pending tx=0, bit count=0, state=IDLE
//   - synchronizers preset to idle levels (SCLK=0, SS_n=1)
// - Synchronization and edge detection:
//   - Each input passes SYNC_STAGES flops, then one history flop.
//   - Edges are detected from synced vs. history: sclk_rise, sclk_fall, ss_fall, ss_rise.
//   - MOSI is delayed by the same stage count, so it aligns with its SCLK edge.
// - Mode 0:
//   - Sample MOSI on sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}; bit count++.
//   - Advance MISO on sclk_fall: tx_shift <= {tx_shift[DATA_W-2:0],1'b0}.
//   - MISO = tx_shift[DATA_W-1] while MISO_en; MISO = 0 otherwise.
// - FSM states IDLE, SHIFT, DONE:
//   - IDLE: on ss_fall, tx_shift <= pending tx, bit count <= 0, MISO_en <= 1, go to SHIFT.
//     The MSB is on MISO the clock after ss_fall detection.
//   - SHIFT: shift per the edge rules above. On ss_rise go to DONE and set MISO_en <= 0.
//     If sclk_rise and ss_rise are detected in the same clk, the sample is taken first, then DONE.
//   - DONE (one clk): if bit count == DATA_W, rx_data <= rx_shift and rx_rdy=1.
//     Otherwise frm_err=1 and rx_data is unchanged. Always return to IDLE.
// - Latency: rx_rdy rises SYNC_STAGES+2 clks after the SS_n pin rises.
// - Bit count saturates at DATA_W+1. Extra SCLK rises keep shifting rx_shift but force frm_err.
// - Early SS_n rise (<DATA_W bits) gives frm_err. A partial word is never published.
// - SCLK edges while in IDLE (SS_n high) are ignored. Only ss_fall starts a frame.
// - tx_wrt:
//   - Always updates the pending tx register. It never disturbs tx_shift mid-frame.
//   - Mid-frame writes apply to the next frame. If tx_wrt coincides with ss_fall, the new tx_data is used.
//   - A pending word is reused for every frame until rewritten.
// - rst asserted mid-frame: immediate return to IDLE with no rx_rdy or frm_err.
//   A still-low SS_n does not start a frame until it rises and falls again.
// TESTING
// 1. tx_wrt with tx_data=16'hA55A, then master sends 16'h1234 at clk/32 SCLK
//    -> rx_rdy pulses once, rx_data=16'h1234; master reads 16'hA55A.
// 2. Back-to-back frames 16'hFFFF then 16'h0001, with no tx_wrt between them
//    -> two rx_rdy pulses, rx_data sequence FFFF then 0001; MISO returns A55A both times.
// 3. SS_n raised after 9 SCLK rises -> frm_err pulse, no rx_rdy, rx_data holds previous value.
// 4. 17 SCLK rises in one frame -> frm_err pulse, no rx_rdy.
// 5. tx_wrt 16'h0F0F during a frame -> current frame still returns old word; next frame returns 16'h0F0F.
// 6. rst pulsed at bit 8 with SS_n held low -> busy=0, MISO_en=0, no pulses; next full frame received correctly.

Source files
------------

// File: rtl/spi_slave16.sv
// Mode-0 SPI responder: receives one DATA_W frame per SS_n low period
// and returns a preloaded tx word on MISO in the same frame.
module spi_slave16 #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_en,
  input  logic              tx_wrt,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_rdy,
  output logic              frm_err,
  output logic              busy
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   ss_hist_q, ss_hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   armed_q, armed_d;

  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              miso_en_q, miso_en_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              frm_err_q, frm_err_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic start;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    ss_hist_d   = ss_s;
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    ss_fall     = ~ss_s & ss_hist_q;
    ss_rise     = ss_s & ~ss_hist_q;
    // Only arm once the preset chain holds real pin samples and SS_n is high,
    // so an SS_n held low across reset cannot fake a frame start.
    fill_d  = (fill_q == FILL_W'(SYNC_STAGES)) ? fill_q : fill_q + FILL_W'(1);
    armed_d = armed_q | ((fill_q == FILL_W'(SYNC_STAGES)) & ss_s);
    start   = (state_q == IDLE) & ss_fall & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      pend_q      <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      miso_en_q   <= 1'b0;
      rx_rdy_q    <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      ss_hist_q   <= ss_hist_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      miso_en_q   <= miso_en_d;
      rx_rdy_q    <= rx_rdy_d;
      frm_err_q   <= frm_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d     = tx_wrt ? tx_data : pend_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    miso_en_d  = miso_en_q;
    rx_rdy_d   = 1'b0;
    frm_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = pend_d;
          cnt_d      = '0;
          miso_en_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (cnt_q != CNT_W'(DATA_W + 1)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (sclk_fall) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        if (ss_rise) miso_en_d = 1'b0;
      end
      DONE: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          rx_data_d = rx_shift_q;
          rx_rdy_d  = 1'b1;
        end else begin
          frm_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q == SHIFT);
    MISO    = miso_en_q & tx_shift_q[DATA_W-1];
    MISO_en = miso_en_q;
    rx_data = rx_data_q;
    rx_rdy  = rx_rdy_q;
    frm_err = frm_err_q;
  end

endmodule
